// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/sub sequencer driving an external 1-bit full-adder cell
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B at capture and force the carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= op ? ~b : b;
                        carry <= op ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    acc   <= {fa_s, acc[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    // carry still holds the carry into the MSB on the final bit
                    if (last_bit) begin
                        sum  <= {fa_s, acc[WIDTH-1:1]};
                        cout <= fa_co;
                        ovf  <= fa_co ^ carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fa_a  = a_sh[0];
    assign fa_b  = b_sh[0];
    assign fa_ci = carry;
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl with a half-adder based FA cell
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         fa_a, fa_b, fa_ci, fa_s, fa_co;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    // Full adder from two half adders plus OR
    logic ha1_s, ha1_c, ha2_c;
    assign ha1_s = fa_a ^ fa_b;
    assign ha1_c = fa_a & fa_b;
    assign fa_s  = ha1_s ^ fa_ci;
    assign ha2_c = ha1_s & fa_ci;
    assign fa_co = ha1_c | ha2_c;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W+1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic c);
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic         v;
        yy   = o ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (o ? 1'b1 : c)};
        v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return {full[W-1:0], full[W], v};
    endfunction

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: sum=%0h cout=%0b ovf=%0b, expected no result", sum, cout, ovf);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                if ({sum, cout, ovf} !== e) begin
                    n_bad++;
                    $display("FAIL result: sum=%0h cout=%0b ovf=%0b, expected sum=%0h cout=%0b ovf=%0b",
                             sum, cout, ovf, e[W+1:2], e[1], e[0]);
                end
            end
        end
    end

    // Issue one operation; optionally check busy/done timing against the accept edge.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W+1:0] e, input bit timing);
        int cyc;
        @(negedge clk);
        op = o; a = x; b = y; cin = c; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            if (timing) chk("busy_in_run", {31'd0, busy}, 32'd1);
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout", 32'(cyc), 32'(W + 1));
        else if (timing) begin
            chk("done_latency", 32'(cyc), 32'(W + 1));
            chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int cyc;
        bit quiet;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {23'd0, busy, done, sum, cout, ovf, fa_a, fa_b, fa_ci}, 32'd0);
        rst_n = 1'b1;

        run_op(1'b0, 4'h0, 4'h0, 1'b0, {4'h0, 1'b0, 1'b0}, 1'b1);
        run_op(1'b0, 4'hF, 4'h1, 1'b0, {4'h0, 1'b1, 1'b0}, 1'b1);
        run_op(1'b0, 4'h7, 4'h1, 1'b0, {4'h8, 1'b0, 1'b1}, 1'b1);
        run_op(1'b1, 4'h5, 4'h3, 1'b0, {4'h2, 1'b1, 1'b0}, 1'b1);
        run_op(1'b1, 4'h3, 4'h5, 1'b0, {4'hE, 1'b0, 1'b0}, 1'b1);
        run_op(1'b1, 4'h8, 4'h1, 1'b0, {4'h7, 1'b1, 1'b1}, 1'b1);
        chk("hold_between_runs", {27'd0, sum, ovf}, {27'd0, 4'h7, 1'b1});

        // start held high through RUN and DONE while operands wander
        @(negedge clk);
        op = 1'b0; a = 4'h6; b = 4'h3; cin = 1'b0; start = 1'b1;
        exp_q.push_back({4'h9, 1'b0, 1'b1});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            op = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
        end while (!done && cyc < 20);
        start = 1'b0;
        chk("held_start_latency", 32'(cyc), 32'(W + 1));
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (busy || done) quiet = 1'b0;
        end
        chk("held_start_single", {31'd0, quiet}, 32'd1);

        // Asynchronous reset two edges into RUN
        @(negedge clk);
        op = 1'b0; a = 4'hF; b = 4'hF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {23'd0, busy, done, sum, cout, ovf, fa_a, fa_b, fa_ci}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) quiet = 1'b0;
        end
        chk("no_done_after_reset", {31'd0, quiet}, 32'd1);
        run_op(1'b0, 4'h9, 4'h4, 1'b1, {4'hE, 1'b0, 1'b0}, 1'b1);

        // Exhaustive back-to-back sweep against the reference model
        for (int o = 0; o < 2; o++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        run_op(1'(o), 4'(x), 4'(y), 1'(c), model(1'(o), 4'(x), 4'(y), 1'(c)), 1'b0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
